leaf_user_fifo_bank: RTL and testbench
======================================

Name: leaf_user_fifo_bank

Overview:
Parametrised buffering stage between the leaf_interface user ports and an HLS kernel inside a page wrapper. It generalises direct point-to-point wiring to NUM_IN_PORTS input channels and NUM_OUT_PORTS output channels. Each channel has its own valid/ready FIFO, a level output and a saturating word counter. It also drives a gated kernel start.

Parameters:
PAYLOAD_BITS, 32, data width per channel
NUM_IN_PORTS, 2, channels from leaf_interface to kernel (>=1)
NUM_OUT_PORTS, 1, channels from kernel to leaf_interface (>=1)
DEPTH_LOG2, 4, per-channel FIFO depth = 2**DEPTH_LOG2 (>=1)
CNT_BITS, 16, width of per-channel word counters
START_MODE, 0, 0 = kernel_start tied high after reset; 1 = kernel_start held low until every input channel has accepted at least one word

Ports:
clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all state, active-high
ifc_in_data  in  NUM_IN_PORTS*PAYLOAD_BITS  leaf_interface -> bank data, channel i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
ifc_in_valid  in  NUM_IN_PORTS  per-channel valid
ifc_in_ready  out  NUM_IN_PORTS  per-channel ready (FIFO not full)
krn_in_data  out  NUM_IN_PORTS*PAYLOAD_BITS  bank -> kernel data
krn_in_valid  out  NUM_IN_PORTS  per-channel valid (FIFO not empty)
krn_in_ready  in  NUM_IN_PORTS  kernel ready
krn_out_data  in  NUM_OUT_PORTS*PAYLOAD_BITS  kernel -> bank data
krn_out_valid  in  NUM_OUT_PORTS  kernel valid
krn_out_ready  out  NUM_OUT_PORTS  bank ready to kernel
ifc_out_data  out  NUM_OUT_PORTS*PAYLOAD_BITS  bank -> leaf_interface data
ifc_out_valid  out  NUM_OUT_PORTS  valid to leaf_interface
ifc_out_ready  in  NUM_OUT_PORTS  leaf_interface ready
in_level  out  NUM_IN_PORTS*(DEPTH_LOG2+1)  occupancy per input FIFO
out_level  out  NUM_OUT_PORTS*(DEPTH_LOG2+1)  occupancy per output FIFO
in_word_cnt  out  NUM_IN_PORTS*CNT_BITS  words accepted per input channel
out_word_cnt  out  NUM_OUT_PORTS*CNT_BITS  words delivered per output channel
kernel_start  out  1  drives kernel ap_start

Behaviour:
- Channel FIFOs are independent and identical. A push occurs on valid&&ready at the write side. A pop occurs on valid&&ready at the read side.
- Ready to the writer = (level != 2**DEPTH_LOG2), registered state only. A pop in the same cycle does not raise ready; when full, no push is accepted that cycle.
- Valid to the reader = (level != 0). Data is the head entry, first-word fall-through from storage.
- Minimum latency: a word pushed in cycle N is visible with valid=1 in cycle N+1. There is no combinational input-to-output bypass.
- Simultaneous push and pop when 0<level<depth: level unchanged, order preserved.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Level is DEPTH_LOG2+1 bits, range 0..depth.
- Word counters increment on each push (in_word_cnt) or each pop to leaf_interface (out_word_cnt). They saturate at 2**CNT_BITS-1 and do not wrap.
- kernel_start, START_MODE=0: 0 in reset, 1 from the first clock after deassertion.
- kernel_start, START_MODE=1: per-channel seen flag set on the first push. kernel_start = AND of all seen flags, registered, so it rises the cycle after the last flag sets. It is sticky until reset or flush.
- Reset (ap_rst_n=0, async, any time including mid-transfer):
  - all levels, pointers, counters, seen flags = 0
  - ifc_in_ready = krn_out_ready = 0
  - krn_in_valid = ifc_out_valid = 0
  - kernel_start = 0
  - data outputs don't-care
  - In-flight words are discarded.
- Readies rise in the first clock after ap_rst_n deasserts.
- flush=1 is sampled at a clock edge and has the same effect as reset on the next cycle state. While flush=1, all readies and valids are forced to 0 combinationally, so no transfer occurs. flush has priority over a simultaneous push or pop.
- Storage is in registers or distributed RAM. Storage contents need no reset.

Test Plan:
- Reset then PAYLOAD_BITS=32, DEPTH_LOG2=2: push 0x11,0x22,0x33,0x44 on input ch0 with krn_in_ready=0 -> level 4, ifc_in_ready[0]=0. Release ready -> pops 0x11..0x44 in order, one per cycle.
- Full FIFO with simultaneous ifc_in_valid=1 and krn_in_ready=1 -> one pop, no push that cycle; level 4->3, ready returns to 1 next cycle.
- START_MODE=1, two inputs: push ch0 only -> kernel_start stays 0. Push ch1 at cycle T -> kernel_start=1 at T+1 and stays 1 through later empty periods.
- CNT_BITS=4: push 20 words on ch1 with continuous drain -> in_word_cnt[ch1]=15, not 4.
- Assert ap_rst_n=0 asynchronously between edges with 3 words buffered -> outputs go to reset values immediately. After release, level=0, no stale word appears.
- flush pulse concurrent with push and pop on all channels -> no transfer handshake completes that cycle; all levels, counters and kernel_start read 0 on the following cycle.

Source files
------------

// File: rtl/leaf_user_fifo_bank.sv
// leaf_user_fifo_bank
// Buffers user channels between the leaf interface and an HLS kernel.
// Each input channel (leaf -> kernel) and output channel (kernel -> leaf)
// gets an independent first-word-fall-through FIFO, a level output and a
// saturating word counter. The bank also drives the kernel's ap_start,
// either tied high after reset or gated on every input channel having
// received at least one word.

// One FIFO channel: register-array storage, FWFT head, level, word counter.
module leaf_user_fifo_chan #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_LOG2   = 4,
    parameter int CNT_BITS     = 16,
    // 0: count words pushed on the write side; 1: count words popped
    parameter bit COUNT_ON_POP = 1'b0
) (
    input  logic                    clk,
    input  logic                    ap_rst_n,
    input  logic                    flush,
    input  logic                    enable,
    input  logic [PAYLOAD_BITS-1:0] wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [PAYLOAD_BITS-1:0] rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DEPTH_LOG2:0]     level,
    output logic [CNT_BITS-1:0]     word_cnt,
    output logic                    push
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [CNT_BITS-1:0]   CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0]   CNT_MAX  = {CNT_BITS{1'b1}};

    logic [PAYLOAD_BITS-1:0] mem_q [0:DEPTH-1];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  pop;
    logic                  count_evt;

    // Handshakes depend on registered state only; flush blocks both sides.
    always_comb begin
        wr_ready  = enable && !flush && (level_q != LVL_FULL);
        rd_valid  = !flush && (level_q != '0);
        rd_data   = mem_q[rd_ptr_q];
        push      = wr_valid && wr_ready;
        pop       = rd_valid && rd_ready;
        count_evt = COUNT_ON_POP ? pop : push;
        level     = level_q;
        word_cnt  = cnt_q;
    end

    // Next-state for pointers, level and counter; flush clears everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
            if (count_evt && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write; contents are never reset, pointers decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// Bank top: replicates the channel FIFO and generates kernel_start.
module leaf_user_fifo_bank #(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_IN_PORTS  = 2,
    parameter int NUM_OUT_PORTS = 1,
    parameter int DEPTH_LOG2    = 4,
    parameter int CNT_BITS      = 16,
    parameter int START_MODE    = 0
) (
    input  logic                                    clk,
    input  logic                                    ap_rst_n,
    input  logic                                    flush,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    ifc_in_data,
    input  logic [NUM_IN_PORTS-1:0]                 ifc_in_valid,
    output logic [NUM_IN_PORTS-1:0]                 ifc_in_ready,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    krn_in_data,
    output logic [NUM_IN_PORTS-1:0]                 krn_in_valid,
    input  logic [NUM_IN_PORTS-1:0]                 krn_in_ready,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   krn_out_data,
    input  logic [NUM_OUT_PORTS-1:0]                krn_out_valid,
    output logic [NUM_OUT_PORTS-1:0]                krn_out_ready,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   ifc_out_data,
    output logic [NUM_OUT_PORTS-1:0]                ifc_out_valid,
    input  logic [NUM_OUT_PORTS-1:0]                ifc_out_ready,
    output logic [NUM_IN_PORTS*(DEPTH_LOG2+1)-1:0]  in_level,
    output logic [NUM_OUT_PORTS*(DEPTH_LOG2+1)-1:0] out_level,
    output logic [NUM_IN_PORTS*CNT_BITS-1:0]        in_word_cnt,
    output logic [NUM_OUT_PORTS*CNT_BITS-1:0]       out_word_cnt,
    output logic                                    kernel_start
);

    localparam int LW = DEPTH_LOG2 + 1;

    // alive_q holds readies low through reset/flush and for no longer.
    logic                    alive_q, alive_d;
    logic [NUM_IN_PORTS-1:0] seen_q, seen_d;
    logic                    kernel_start_q, kernel_start_d;
    logic [NUM_IN_PORTS-1:0] in_push;
    logic [NUM_OUT_PORTS-1:0] out_push_unused;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
            leaf_user_fifo_chan #(
                .PAYLOAD_BITS (PAYLOAD_BITS),
                .DEPTH_LOG2   (DEPTH_LOG2),
                .CNT_BITS     (CNT_BITS),
                .COUNT_ON_POP (1'b0)
            ) u_chan (
                .clk      (clk),
                .ap_rst_n (ap_rst_n),
                .flush    (flush),
                .enable   (alive_q),
                .wr_data  (ifc_in_data[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
                .wr_valid (ifc_in_valid[gi]),
                .wr_ready (ifc_in_ready[gi]),
                .rd_data  (krn_in_data[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
                .rd_valid (krn_in_valid[gi]),
                .rd_ready (krn_in_ready[gi]),
                .level    (in_level[gi*LW +: LW]),
                .word_cnt (in_word_cnt[gi*CNT_BITS +: CNT_BITS]),
                .push     (in_push[gi])
            );
        end

        for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out
            leaf_user_fifo_chan #(
                .PAYLOAD_BITS (PAYLOAD_BITS),
                .DEPTH_LOG2   (DEPTH_LOG2),
                .CNT_BITS     (CNT_BITS),
                .COUNT_ON_POP (1'b1)
            ) u_chan (
                .clk      (clk),
                .ap_rst_n (ap_rst_n),
                .flush    (flush),
                .enable   (alive_q),
                .wr_data  (krn_out_data[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
                .wr_valid (krn_out_valid[gi]),
                .wr_ready (krn_out_ready[gi]),
                .rd_data  (ifc_out_data[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
                .rd_valid (ifc_out_valid[gi]),
                .rd_ready (ifc_out_ready[gi]),
                .level    (out_level[gi*LW +: LW]),
                .word_cnt (out_word_cnt[gi*CNT_BITS +: CNT_BITS]),
                .push     (out_push_unused[gi])
            );
        end
    endgenerate

    // Start gating: seen flags include this cycle's push so the start flop
    // rises on the edge right after the last channel's first word.
    always_comb begin
        alive_d        = !flush;
        seen_d         = flush ? '0 : (seen_q | in_push);
        kernel_start_d = 1'b0;
        if (!flush) begin
            if (START_MODE == 0) begin
                kernel_start_d = 1'b1;
            end else begin
                kernel_start_d = kernel_start_q || (&seen_d);
            end
        end
        kernel_start = kernel_start_q;
    end

    // Bank-level state registers.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            alive_q        <= 1'b0;
            seen_q         <= '0;
            kernel_start_q <= 1'b0;
        end else begin
            alive_q        <= alive_d;
            seen_q         <= seen_d;
            kernel_start_q <= kernel_start_d;
        end
    end

endmodule

// File: tb/tb_leaf_user_fifo_bank.sv
// Directed bench for leaf_user_fifo_bank: 32-bit payload, two input
// channels, one output channel, depth 4, 4-bit counters, gated start.
module tb_leaf_user_fifo_bank;

    localparam int PB = 32;
    localparam int NI = 2;
    localparam int NO = 1;
    localparam int DL = 2;
    localparam int CB = 4;
    localparam int LW = DL + 1;

    logic              clk = 1'b0;
    logic              ap_rst_n;
    logic              flush;
    logic [NI*PB-1:0]  ifc_in_data;
    logic [NI-1:0]     ifc_in_valid;
    logic [NI-1:0]     ifc_in_ready;
    logic [NI*PB-1:0]  krn_in_data;
    logic [NI-1:0]     krn_in_valid;
    logic [NI-1:0]     krn_in_ready;
    logic [NO*PB-1:0]  krn_out_data;
    logic [NO-1:0]     krn_out_valid;
    logic [NO-1:0]     krn_out_ready;
    logic [NO*PB-1:0]  ifc_out_data;
    logic [NO-1:0]     ifc_out_valid;
    logic [NO-1:0]     ifc_out_ready;
    logic [NI*LW-1:0]  in_level;
    logic [NO*LW-1:0]  out_level;
    logic [NI*CB-1:0]  in_word_cnt;
    logic [NO*CB-1:0]  out_word_cnt;
    logic              kernel_start;

    int n_cmp = 0;
    int n_bad = 0;

    leaf_user_fifo_bank #(
        .PAYLOAD_BITS (PB), .NUM_IN_PORTS (NI), .NUM_OUT_PORTS (NO),
        .DEPTH_LOG2 (DL), .CNT_BITS (CB), .START_MODE (1)
    ) dut (
        .clk (clk), .ap_rst_n (ap_rst_n), .flush (flush),
        .ifc_in_data (ifc_in_data), .ifc_in_valid (ifc_in_valid),
        .ifc_in_ready (ifc_in_ready), .krn_in_data (krn_in_data),
        .krn_in_valid (krn_in_valid), .krn_in_ready (krn_in_ready),
        .krn_out_data (krn_out_data), .krn_out_valid (krn_out_valid),
        .krn_out_ready (krn_out_ready), .ifc_out_data (ifc_out_data),
        .ifc_out_valid (ifc_out_valid), .ifc_out_ready (ifc_out_ready),
        .in_level (in_level), .out_level (out_level),
        .in_word_cnt (in_word_cnt), .out_word_cnt (out_word_cnt),
        .kernel_start (kernel_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-20s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ap_rst_n = 1'b0; flush = 1'b0;
        ifc_in_data = '0; ifc_in_valid = '0; krn_in_ready = '0;
        krn_out_data = '0; krn_out_valid = '0; ifc_out_ready = '0;
        #12;
        chk("rst_in_ready", 32'(ifc_in_ready), 32'h0);
        chk("rst_krn_valid", 32'(krn_in_valid), 32'h0);
        chk("rst_out_ready", 32'(krn_out_ready), 32'h0);
        chk("rst_kstart", 32'(kernel_start), 32'h0);
        ap_rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(ifc_in_ready), 32'h3);
        chk("post_rst_out_ready", 32'(krn_out_ready), 32'h1);

        // Fill ch0 with the kernel stalled.
        ifc_in_valid = 2'b01;
        ifc_in_data[0 +: PB] = 32'h11; tick();
        chk("ch0_first_valid", 32'(krn_in_valid[0]), 32'h1);
        ifc_in_data[0 +: PB] = 32'h22; tick();
        ifc_in_data[0 +: PB] = 32'h33; tick();
        ifc_in_data[0 +: PB] = 32'h44; tick();
        chk("ch0_full_level", 32'(in_level[0 +: LW]), 32'h4);
        chk("ch0_full_ready", 32'(ifc_in_ready[0]), 32'h0);
        chk("ch0_head", krn_in_data[0 +: PB], 32'h11);
        chk("ch0_cnt4", 32'(in_word_cnt[0 +: CB]), 32'h4);
        chk("kstart_ch0_only", 32'(kernel_start), 32'h0);

        // Full with push offered and a pop: only the pop happens.
        ifc_in_data[0 +: PB] = 32'h55;
        krn_in_ready = 2'b01;
        tick();
        chk("full_pop_level", 32'(in_level[0 +: LW]), 32'h3);
        chk("full_pop_ready", 32'(ifc_in_ready[0]), 32'h1);
        chk("ch0_head2", krn_in_data[0 +: PB], 32'h22);
        ifc_in_valid = 2'b00;
        tick();
        chk("ch0_head3", krn_in_data[0 +: PB], 32'h33);
        tick();
        chk("ch0_head4", krn_in_data[0 +: PB], 32'h44);
        tick();
        chk("ch0_drained_valid", 32'(krn_in_valid[0]), 32'h0);
        chk("ch0_cnt_no_push", 32'(in_word_cnt[0 +: CB]), 32'h4);
        krn_in_ready = 2'b00;

        // First word on ch1 completes the start gate.
        ifc_in_valid = 2'b10;
        ifc_in_data[PB +: PB] = 32'hA1;
        chk("kstart_before_T", 32'(kernel_start), 32'h0);
        tick();
        chk("kstart_T_plus_1", 32'(kernel_start), 32'h1);
        ifc_in_valid = 2'b00;
        krn_in_ready = 2'b10;
        tick();
        chk("ch1_empty", 32'(in_level[LW +: LW]), 32'h0);
        tick();
        chk("kstart_sticky", 32'(kernel_start), 32'h1);

        // Saturation: 20 more words on ch1 with continuous drain.
        ifc_in_valid = 2'b10;
        for (int i = 0; i < 20; i++) begin
            ifc_in_data[PB +: PB] = 32'(i + 1);
            tick();
        end
        chk("ch1_cnt_sat", 32'(in_word_cnt[LW - LW + CB +: CB]), 32'hF);
        chk("ch1_level_steady", 32'(in_level[LW +: LW]), 32'h1);
        chk("ch1_head_last", krn_in_data[PB +: PB], 32'd20);
        ifc_in_valid = 2'b00;
        tick();
        chk("ch1_drain_level", 32'(in_level[LW +: LW]), 32'h0);
        krn_in_ready = 2'b00;

        // Output channel: buffer two words, then deliver them.
        krn_out_valid = 1'b1;
        krn_out_data = 32'hBEEF0001; tick();
        chk("out_valid", 32'(ifc_out_valid), 32'h1);
        chk("out_head1", ifc_out_data, 32'hBEEF0001);
        krn_out_data = 32'hBEEF0002; tick();
        chk("out_level2", 32'(out_level), 32'h2);
        krn_out_valid = 1'b0;
        ifc_out_ready = 1'b1;
        tick();
        chk("out_cnt1", 32'(out_word_cnt), 32'h1);
        chk("out_head2", ifc_out_data, 32'hBEEF0002);
        tick();
        chk("out_cnt2", 32'(out_word_cnt), 32'h2);
        chk("out_empty", 32'(ifc_out_valid), 32'h0);
        ifc_out_ready = 1'b0;

        // Asynchronous reset mid-cycle with three words buffered on ch0.
        ifc_in_valid = 2'b01;
        ifc_in_data[0 +: PB] = 32'h71; tick();
        ifc_in_data[0 +: PB] = 32'h72; tick();
        ifc_in_data[0 +: PB] = 32'h73; tick();
        ifc_in_valid = 2'b00;
        chk("pre_arst_level", 32'(in_level[0 +: LW]), 32'h3);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(in_level[0 +: LW]), 32'h0);
        chk("arst_krn_valid", 32'(krn_in_valid), 32'h0);
        chk("arst_in_ready", 32'(ifc_in_ready), 32'h0);
        chk("arst_kstart", 32'(kernel_start), 32'h0);
        chk("arst_cnt", 32'(in_word_cnt), 32'h0);
        chk("arst_out_cnt", 32'(out_word_cnt), 32'h0);
        #2;
        ap_rst_n = 1'b1;
        tick();
        chk("rel_in_ready", 32'(ifc_in_ready), 32'h3);
        chk("rel_no_stale", 32'(krn_in_valid), 32'h0);

        // Load every channel, then flush during push+pop on all of them.
        ifc_in_valid = 2'b11;
        ifc_in_data = {32'hC1, 32'hC0};
        krn_out_valid = 1'b1;
        krn_out_data = 32'hD0;
        tick();
        chk("both_seen_kstart", 32'(kernel_start), 32'h1);
        chk("pre_flush_lvl0", 32'(in_level[0 +: LW]), 32'h1);
        krn_in_ready = 2'b11;
        ifc_out_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(ifc_in_ready), 32'h0);
        chk("flush_krn_valid", 32'(krn_in_valid), 32'h0);
        chk("flush_out_ready", 32'(krn_out_ready), 32'h0);
        chk("flush_out_valid", 32'(ifc_out_valid), 32'h0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        ifc_in_valid = 2'b00;
        krn_out_valid = 1'b0;
        #1;
        chk("flush_in_level", 32'(in_level), 32'h0);
        chk("flush_out_level", 32'(out_level), 32'h0);
        chk("flush_in_cnt", 32'(in_word_cnt), 32'h0);
        chk("flush_out_cnt", 32'(out_word_cnt), 32'h0);
        chk("flush_kstart", 32'(kernel_start), 32'h0);
        tick();
        chk("post_flush_ready", 32'(ifc_in_ready), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
